// File: rtl/mem_req_ctrl.sv
// Purpose: sequences byte/half/word loads and stores onto a word-wide memory port, with read-modify-write for sub-word stores.
// Latency: response strobe 1 (error), 2 (word store), 3 (load) or 4 (sub-word store) edges after acceptance.
// Backpressure: req_ready is high only in IDLE; one request is in flight at a time.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   req_valid/req_ready          request handshake; req_we, req_size, req_signed, req_addr, req_wdata carry the request
//   resp_valid/resp_rdata/resp_err  one-cycle completion strobe with load data and error flag
//   mem_enable/mem_wr_en/mem_address/mem_data_in  memory command; mem_contents returns read data one cycle later
module mem_req_ctrl #(
    parameter logic BIG_ENDIAN     = 1'b1,
    parameter logic WORD_ADDR_MASK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_enable,
    output logic        mem_wr_en,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_contents
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RDW  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        r_mem_enable;
    logic        r_mem_wr_en;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_data_in;

    logic        w_req_err;
    logic [4:0]  w_shift;
    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;
    logic [31:0] w_load;
    logic [31:0] w_mask;
    logic [31:0] w_merge;

    assign req_ready = (r_state == IDLE) && !rst;

    // Alignment/size check on the live request fields, used at acceptance only.
    always_comb begin
        w_req_err = 1'b0;
        case (req_size)
            2'b01:   w_req_err = req_addr[0];
            2'b10:   w_req_err = |req_addr[1:0];
            2'b11:   w_req_err = 1'b1;
            default: w_req_err = 1'b0;
        endcase
    end

    // Bit position of the addressed lane inside the word. Big-endian puts the
    // lowest byte address in the most significant lane, so the lane of an
    // n-byte access at offset o starts at bit 8*(4-n-o).
    always_comb begin
        w_shift = 5'd0;
        if (BIG_ENDIAN) begin
            case (r_size)
                2'b00:   w_shift = {~r_addr[1:0], 3'b000};
                2'b01:   w_shift = {~r_addr[1], 4'b0000};
                default: w_shift = 5'd0;
            endcase
        end else begin
            case (r_size)
                2'b00:   w_shift = {r_addr[1:0], 3'b000};
                2'b01:   w_shift = {r_addr[1], 4'b0000};
                default: w_shift = 5'd0;
            endcase
        end
    end

    assign w_rd_byte = 8'(mem_contents >> w_shift);
    assign w_rd_half = 16'(mem_contents >> w_shift);

    always_comb begin
        w_load = mem_contents;
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_rd_byte[7]}}, w_rd_byte};
            2'b01:   w_load = {{16{r_signed & w_rd_half[15]}}, w_rd_half};
            default: w_load = mem_contents;
        endcase
    end

    // Sub-word store: overwrite only the addressed lane of the word just read.
    assign w_mask  = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shift;
    assign w_merge = (mem_contents & ~w_mask) | ((r_wdata << w_shift) & w_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_we          <= 1'b0;
            r_size        <= 2'b00;
            r_signed      <= 1'b0;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= 32'd0;
            r_resp_err    <= 1'b0;
            r_mem_enable  <= 1'b0;
            r_mem_wr_en   <= 1'b0;
            r_mem_address <= 32'd0;
            r_mem_data_in <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we          <= req_we;
                        r_size        <= req_size;
                        r_signed      <= req_signed;
                        r_addr        <= req_addr;
                        r_wdata       <= req_wdata;
                        r_mem_address <= WORD_ADDR_MASK ? {req_addr[31:2], 2'b00} : req_addr;
                        if (w_req_err) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'd0;
                        end else if (req_we && (req_size == 2'b10)) begin
                            r_state       <= WR;
                            r_mem_enable  <= 1'b1;
                            r_mem_wr_en   <= 1'b1;
                            r_mem_data_in <= req_wdata;
                        end else begin
                            r_state      <= RD;
                            r_mem_enable <= 1'b1;
                            r_mem_wr_en  <= 1'b0;
                        end
                    end
                end
                RD: begin
                    r_state      <= RDW;
                    r_mem_enable <= 1'b0;
                end
                RDW: begin
                    // mem_contents now holds the word addressed during RD.
                    if (r_we) begin
                        r_state       <= WR;
                        r_mem_enable  <= 1'b1;
                        r_mem_wr_en   <= 1'b1;
                        r_mem_data_in <= w_merge;
                    end else begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_load;
                    end
                end
                WR: begin
                    r_state      <= RESP;
                    r_mem_enable <= 1'b0;
                    r_mem_wr_en  <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'd0;
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'd0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_mem_enable <= 1'b0;
                    r_mem_wr_en  <= 1'b0;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;
    assign mem_enable  = r_mem_enable;
    assign mem_wr_en   = r_mem_wr_en;
    assign mem_address = r_mem_address;
    assign mem_data_in = r_mem_data_in;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Purpose: checks mem_req_ctrl against a byte-addressed big-endian memory reference model.
// Latency: measured per request as edges from acceptance to the response strobe.
// Backpressure: requests are driven one at a time; one scenario holds req_valid high.
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_enable;
    logic        mem_wr_en;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_contents;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_req_ctrl #(.BIG_ENDIAN(1'b1), .WORD_ADDR_MASK(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_enable   (mem_enable),
        .mem_wr_en    (mem_wr_en),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_contents (mem_contents)
    );

    // Bus-level memory seen by the DUT: 16 words, read data one cycle after the read.
    logic [31:0] mem_words [0:15];
    logic [31:0] mem_rd_q;
    logic        mem_clr;
    assign mem_contents = mem_rd_q;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem_words[i] <= 32'd0;
            mem_rd_q <= 32'd0;
        end else if (mem_enable) begin
            if (mem_wr_en) mem_words[mem_address[5:2]] <= mem_data_in;
            else           mem_rd_q <= mem_words[mem_address[5:2]];
        end
    end

    // Reference: flat byte array, lowest address is the most significant byte.
    logic [7:0] rb [0:63];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < 4; i++) v = (v << 8) | 32'(rb[int'(((a & ~32'd3) + 32'(i)) & 32'd63)]);
        return v;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input logic sg);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(rb[int'((a + 32'(i)) & 32'd63)]);
        if (n == 1 && sg && v[7])  v = v | 32'hFFFF_FF00;
        if (n == 2 && sg && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // Issue one request from a negedge, follow it to completion, return at a negedge in IDLE.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd);
        int          n, exp_lat, exp_rd, exp_wr, lat, nrd, nwr;
        logic        err;
        logic [31:0] exp_rdata, exp_wword;
        logic [7:0]  nb [0:63];

        n   = (sz == 2'b11) ? 4 : (1 << sz);
        err = (sz == 2'b11) || ((addr % 32'(n)) != 0);
        exp_rdata = 32'd0;
        exp_wword = 32'd0;
        if (err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!we) begin
            exp_lat = 3; exp_rd = 1; exp_wr = 0;
            exp_rdata = (n == 4) ? ref_word(addr) : ref_load(addr, n, sg);
        end else begin
            exp_lat = (n == 4) ? 2 : 4; exp_rd = (n == 4) ? 0 : 1; exp_wr = 1;
            nb = rb;
            for (int i = 0; i < n; i++) nb[int'((addr + 32'(i)) & 32'd63)] = 8'(wd >> (8 * (n - 1 - i)));
            rb = nb;
            exp_wword = ref_word(addr);
        end

        req_we = we; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        chk("ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Scramble the inputs: the captured copy must be the one that counts.
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0; nrd = 0; nwr = 0;
        for (int k = 1; k <= 12; k++) begin
            if (mem_enable) begin
                chk("mem_addr", mem_address, {addr[31:2], 2'b00});
                if (mem_wr_en) begin
                    nwr++;
                    chk("wr_data", mem_data_in, exp_wword);
                end else begin
                    nrd++;
                end
            end
            if (resp_valid) begin
                lat = k;
                chk("rdata", resp_rdata, exp_rdata);
                chk("err", 32'(resp_err), 32'(err));
                break;
            end
            @(negedge clk);
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("n_reads", 32'(nrd), 32'(exp_rd));
        chk("n_writes", 32'(nwr), 32'(exp_wr));
        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
        chk("ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int          nresp, nrdy, cyc0, cyc1, cyc2;
        logic        saw_wr, saw_resp;

        rst = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 64; i++) rb[i] = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_en", {30'd0, mem_enable, mem_wr_en}, 32'd0);
        chk("rst_mem_addr", mem_address, 32'd0);
        chk("rst_mem_data", mem_data_in, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);

        // Directed sequence.
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFF_FF55);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 32'h10, 32'hABCD_1234);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("ref_word_0x10", ref_word(32'h10), 32'h1234_BE55);
        do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'h1111_1111);

        // Reset during the RDW cycle of a byte store: the write must never issue.
        req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h13; req_wdata = 32'h77;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        saw_wr = mem_wr_en; saw_resp = resp_valid;
        @(negedge clk);
        chk("abort_in_rdw", {31'd0, mem_enable}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        saw_wr = saw_wr | mem_wr_en; saw_resp = saw_resp | resp_valid;
        chk("abort_ready_in_rst", 32'(req_ready), 32'd0);
        chk("abort_mem_data", mem_data_in, 32'd0);
        chk("abort_mem_addr", mem_address, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            saw_wr = saw_wr | mem_wr_en; saw_resp = saw_resp | resp_valid;
            if (k == 0) chk("abort_ready_after", 32'(req_ready), 32'd1);
        end
        chk("abort_no_write", 32'(saw_wr), 32'd0);
        chk("abort_no_resp", 32'(saw_resp), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        // req_valid held high across three word loads.
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'd0;
        req_valid = 1'b1;
        nresp = 0; nrdy = 0; cyc0 = 0; cyc1 = 0; cyc2 = 0;
        for (int c = 0; c < 30; c++) begin
            if (req_ready) nrdy++;
            if (resp_valid) begin
                chk("b2b_rdata", resp_rdata, ref_word(32'h10));
                if (nresp == 0) cyc0 = c;
                if (nresp == 1) cyc1 = c;
                if (nresp == 2) cyc2 = c;
                nresp++;
                if (nresp == 3) begin
                    req_valid = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
        chk("b2b_nresp", 32'(nresp), 32'd3);
        chk("b2b_first", 32'(cyc0), 32'd3);
        chk("b2b_gap1", 32'(cyc1 - cyc0), 32'd4);
        chk("b2b_gap2", 32'(cyc2 - cyc1), 32'd4);
        chk("b2b_ready_cnt", 32'(nrdy), 32'd3);
        @(negedge clk);
        @(negedge clk);

        // Randomized traffic over 64 bytes.
        for (int t = 0; t < 60; t++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom),
                   32'($urandom_range(0, 63)), $urandom);
        end
        for (int w = 0; w < 16; w++) chk("final_mem", mem_words[w], ref_word(32'(w * 4)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
